conv_frame_ctrl: RTL

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_frame_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel convolution stage.
// Counts incoming pixels, gates the line-buffer shift and flags complete windows.
module conv_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     iCLK,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode_vert,
  input  logic                     abort,
  input  logic                     iDVAL,
  output logic                     conv_clken,
  output logic                     vertical,
  output logic                     win_valid,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t state;
  logic   accept;
  logic   last_col;
  logic   last_pixel;

  // The pixel presented alongside abort is dropped, so it never reaches the line buffer.
  assign busy       = (state == FILL) || (state == RUN);
  assign accept     = iDVAL && busy && !abort;
  assign conv_clken = accept;
  assign win_valid  = accept && (row >= ROW_WIN0) && (col >= COL_WIN0);
  assign last_col   = (col == COL_LAST);
  assign last_pixel = last_col && (row == ROW_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      vertical    <= 1'b0;
      frame_done  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      overrun_err <= start && busy;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            vertical <= mode_vert;
            col      <= '0;
            row      <= '0;
          end
        end
        FILL, RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col)
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            if (state == FILL && row == ROW_WIN0 && col == COL_WIN0)
              state <= RUN;
            if (state == RUN && last_pixel) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
